// File: rtl/fuzzy_sweep_pkg.sv
// rtl/fuzzy_sweep_pkg.sv - shared types, grid constants and input clamp for the fuzzy sweep driver
//
// Contents:
//   state_t    sweep FSM states
//   GRID_N     points per axis (indices 0..GRID_N-1)
//   CLAMP_LO   smallest value ever driven to the controller inputs
//   CLAMP_HI   largest value ever driven to the controller inputs
//   clamp_raw  maps a 9-bit raw grid value onto CLAMP_LO..CLAMP_HI
package fuzzy_sweep_pkg;

    localparam int         GRID_N   = 17;
    localparam logic [7:0] CLAMP_LO = 8'd1;
    localparam logic [7:0] CLAMP_HI = 8'd254;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST_DUT,
        ST_APPLY,
        ST_SETTLE,
        ST_VALID,
        ST_DONE
    } state_t;

    // The controller's membership functions misbehave at the rails, so the
    // sweep never drives exactly 0 or 255.
    function automatic logic [7:0] clamp_raw(input logic [8:0] raw);
        if (raw == 9'd0) begin
            return CLAMP_LO;
        end else if (raw >= 9'd255) begin
            return CLAMP_HI;
        end else begin
            return raw[7:0];
        end
    endfunction

endpackage

// File: rtl/fuzzy_sweep_driver.sv
// rtl/fuzzy_sweep_driver.sv - walks a 17x17 input grid through a fuzzy controller and streams out captured results
//
// Parameters:
//   STEP     grid increment for both axes
//   SETTLE   cycles inputs are held before the controller output is captured
//   RST_CYC  cycles fz_rst is held at the start of a sweep
// Ports:
//   clk_0          clock, rising edge
//   Srst           synchronous active-high reset
//   start          launch one sweep (only looked at in IDLE)
//   Entrada_01     controller input, outer axis
//   Entrada_02     controller input, inner axis
//   EN_REGRAS      rule enable to the controller
//   fz_rst         controller reset
//   saida_defuzzy  controller output
//   res_valid      capture record valid
//   res_ready      consumer accepts the record
//   res_data       {Entrada_01, Entrada_02, saida_defuzzy}
//   busy           high whenever not IDLE
//   done           one-cycle pulse at sweep end
module fuzzy_sweep_driver
    import fuzzy_sweep_pkg::*;
#(
    parameter int STEP    = 16,
    parameter int SETTLE  = 14,
    parameter int RST_CYC = 2
) (
    input  logic        clk_0,
    input  logic        Srst,
    input  logic        start,
    output logic [7:0]  Entrada_01,
    output logic [7:0]  Entrada_02,
    output logic        EN_REGRAS,
    output logic        fz_rst,
    input  logic [7:0]  saida_defuzzy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_data,
    output logic        busy,
    output logic        done
);

    localparam int         CNT_W    = 16;
    localparam logic [4:0] LAST_IDX = 5'(GRID_N - 1);

    state_t           state;
    state_t           state_nxt;
    logic [4:0]       i_idx;
    logic [4:0]       j_idx;
    logic [4:0]       i_nxt;
    logic [4:0]       j_nxt;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       raw_i;
    logic [8:0]       raw_j;
    logic             last_point;

    assign last_point = (i_idx == LAST_IDX) && (j_idx == LAST_IDX);

    // Raw grid values are formed from the indices the next APPLY will use.
    assign raw_i = 9'(i_nxt) * 9'(STEP);
    assign raw_j = 9'(j_nxt) * 9'(STEP);

    always_comb begin
        state_nxt = state;
        i_nxt     = i_idx;
        j_nxt     = j_idx;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RST_DUT;
                    i_nxt     = '0;
                    j_nxt     = '0;
                end
            end
            ST_RST_DUT: begin
                if (cnt == CNT_W'(RST_CYC - 1)) begin
                    state_nxt = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt == CNT_W'(SETTLE - 1)) begin
                    state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                // res_valid is high for the whole of VALID, so ready alone
                // completes the handshake.
                if (res_ready) begin
                    if (last_point) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_APPLY;
                        if (j_idx == LAST_IDX) begin
                            j_nxt = '0;
                            i_nxt = i_idx + 5'd1;
                        end else begin
                            j_nxt = j_idx + 5'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_0) begin
        if (Srst) begin
            state      <= ST_IDLE;
            i_idx      <= '0;
            j_idx      <= '0;
            cnt        <= '0;
            Entrada_01 <= '0;
            Entrada_02 <= '0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fz_rst     <= 1'b0;
            EN_REGRAS  <= 1'b0;
        end else begin
            state <= state_nxt;
            i_idx <= i_nxt;
            j_idx <= j_nxt;
            // Dwell counter restarts on every state change.
            cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);

            if (state_nxt == ST_APPLY) begin
                Entrada_01 <= clamp_raw(raw_i);
                Entrada_02 <= clamp_raw(raw_j);
            end

            if ((state == ST_SETTLE) && (state_nxt == ST_VALID)) begin
                res_data <= {Entrada_01, Entrada_02, saida_defuzzy};
            end

            // Outputs decode the upcoming state so they are registered yet
            // aligned with the state they describe.
            res_valid <= (state_nxt == ST_VALID);
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
            fz_rst    <= (state_nxt == ST_RST_DUT);
            EN_REGRAS <= (state_nxt == ST_APPLY) || (state_nxt == ST_SETTLE) ||
                         (state_nxt == ST_VALID);
        end
    end

endmodule

// File: tb/tb_fuzzy_sweep_driver.sv
// tb/tb_fuzzy_sweep_driver.sv - self-checking bench for fuzzy_sweep_driver
module tb_fuzzy_sweep_driver;

    logic clk_0 = 1'b0;
    always #5 clk_0 = ~clk_0;

    // default-parameter instance
    logic        Srst, start, res_ready;
    logic [7:0]  Entrada_01, Entrada_02, saida_defuzzy;
    logic        EN_REGRAS, fz_rst, res_valid, busy, done;
    logic [23:0] res_data;

    // SETTLE=3 instance
    logic        srst3, start3, ready3;
    logic [7:0]  e1_3, e2_3, saida3;
    logic        en3, fz3, valid3, busy3, done3;
    logic [23:0] data3;

    assign saida_defuzzy = Entrada_01 ^ Entrada_02;
    assign saida3        = e1_3 ^ e2_3;

    fuzzy_sweep_driver dut (
        .clk_0(clk_0), .Srst(Srst), .start(start),
        .Entrada_01(Entrada_01), .Entrada_02(Entrada_02),
        .EN_REGRAS(EN_REGRAS), .fz_rst(fz_rst), .saida_defuzzy(saida_defuzzy),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done)
    );

    fuzzy_sweep_driver #(.SETTLE(3)) dut3 (
        .clk_0(clk_0), .Srst(srst3), .start(start3),
        .Entrada_01(e1_3), .Entrada_02(e2_3),
        .EN_REGRAS(en3), .fz_rst(fz3), .saida_defuzzy(saida3),
        .res_valid(valid3), .res_ready(ready3), .res_data(data3),
        .busy(busy3), .done(done3)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs_edge = -1;
    logic [23:0] got[$];

    always @(posedge clk_0) cyc <= cyc + 1;

    // Handshake monitor: sampled mid-cycle, the handshake lands on the next edge.
    always @(negedge clk_0) begin
        if (!Srst && res_valid && res_ready) begin
            got.push_back(res_data);
            last_hs_edge <= cyc + 1;
        end
    end

    // Reference: grid point p in sweep order, inner axis fastest.
    function automatic int mclamp(int v);
        if (v == 0) return 1;
        if (v >= 255) return 254;
        return v;
    endfunction

    function automatic logic [23:0] exp_rec(int p);
        int a, b;
        a = mclamp((p / 17) * 16);
        b = mclamp((p % 17) * 16);
        return {8'(a), 8'(b), 8'(a) ^ 8'(b)};
    endfunction

    task automatic step;
        @(posedge clk_0);
        #1;
    endtask

    task automatic do_reset;
        Srst = 1'b1;
        start = 1'b0;
        res_ready = 1'b1;
        step;
        step;
        Srst = 1'b0;
        got.delete();
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            step;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [47:0] v;
        Srst = 1'b1; start = 1'b0; res_ready = 1'b0;
        step;
        v = {Entrada_01, Entrada_02, res_data, res_valid, busy, done, fz_rst, EN_REGRAS, 3'b000};
        checks++;
        if (v !== 48'd0) begin
            failures++;
            $display("FAIL reset_initial: outputs=%h expected 0", v);
        end
        Srst = 1'b0; res_ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        repeat (40) step;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_busy_before: busy=%b expected 1", busy);
        end
        Srst = 1'b1;
        step;
        v = {Entrada_01, Entrada_02, res_data, res_valid, busy, done, fz_rst, EN_REGRAS, 3'b000};
        checks++;
        if (v !== 48'd0) begin
            failures++;
            $display("FAIL reset_midsweep: outputs=%h expected 0", v);
        end
        step;
        step;
        v = {Entrada_01, Entrada_02, res_data, res_valid, busy, done, fz_rst, EN_REGRAS, 3'b000};
        checks++;
        if (v !== 48'd0) begin
            failures++;
            $display("FAIL reset_held: outputs=%h expected 0", v);
        end
        Srst = 1'b0;
        step;
        got.delete();
    endtask

    task automatic test_full_sweep;
        int done_cnt, done_edge, bad;
        done_cnt = 0; done_edge = -1; bad = 0;
        got.delete();
        res_ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            step;
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = cyc;
            end
            if (done_edge >= 0 && cyc > done_edge + 3) break;
        end
        checks++;
        if (got.size() != 289) begin
            failures++;
            $display("FAIL full_count: records=%0d expected 289", got.size());
        end
        if (got.size() == 289) begin
            checks++;
            if (got[0] !== 24'h010100) begin failures++; $display("FAIL full_rec1: got %h expected 010100", got[0]); end
            checks++;
            if (got[1] !== 24'h011011) begin failures++; $display("FAIL full_rec2: got %h expected 011011", got[1]); end
            checks++;
            if (got[16] !== 24'h01feff) begin failures++; $display("FAIL full_rec17: got %h expected 01feff", got[16]); end
            checks++;
            if (got[17] !== 24'h100111) begin failures++; $display("FAIL full_rec18: got %h expected 100111", got[17]); end
            checks++;
            if (got[288] !== 24'hfefe00) begin failures++; $display("FAIL full_rec289: got %h expected fefe00", got[288]); end
            for (int p = 0; p < 289; p++) if (got[p] !== exp_rec(p)) bad++;
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL full_model: mismatching records=%0d expected 0", bad);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL done_width: done cycles=%0d expected 1", done_cnt);
        end
        checks++;
        if (done_edge != last_hs_edge) begin
            failures++;
            $display("FAIL done_timing: done edge=%0d expected %0d", done_edge, last_hs_edge);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL full_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_backpressure;
        logic [23:0] d;
        logic [15:0] e;
        bit stable, seen;
        got.delete();
        res_ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 200 && got.size() < 2; k++) step;
        res_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (res_valid) begin seen = 1'b1; break; end
            step;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL bp_valid_timeout: res_valid=%b expected 1", res_valid);
        end
        d = res_data;
        e = {Entrada_01, Entrada_02};
        checks++;
        if (d !== exp_rec(2)) begin
            failures++;
            $display("FAIL bp_point3: got %h expected %h", d, exp_rec(2));
        end
        stable = 1'b1;
        repeat (50) begin
            step;
            if (!res_valid || res_data !== d || {Entrada_01, Entrada_02} !== e) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            failures++;
            $display("FAIL bp_stable: data=%h inputs=%h expected data=%h inputs=%h", res_data, {Entrada_01, Entrada_02}, d, e);
        end
        checks++;
        if (got.size() != 2) begin
            failures++;
            $display("FAIL bp_no_handshake: records=%0d expected 2", got.size());
        end
        res_ready = 1'b1;
        for (int k = 0; k < 100 && got.size() < 4; k++) step;
        checks++;
        if (got.size() < 4 || got[2] !== exp_rec(2) || got[3] !== 24'h013031) begin
            failures++;
            $display("FAIL bp_resume: records=%0d point4=%h expected 4 records, point4=013031", got.size(), (got.size() >= 4) ? got[3] : 24'h0);
        end
        do_reset;
    endtask

    task automatic test_start_while_busy;
        bit ok;
        int pos, len;
        got.delete();
        res_ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            step;
            if (done) begin ok = 1'b1; break; end
            start = ($urandom_range(0, 19) == 0);
        end
        start = 1'b0;
        step;
        step;
        checks++;
        if (!ok || got.size() != 289 || busy !== 1'b0) begin
            failures++;
            $display("FAIL start_busy: done_seen=%0d records=%0d busy=%b expected 1 289 0", ok, got.size(), busy);
        end
        got.delete();
        start = 1'b1;
        wait_done(6000, ok);
        checks++;
        if (!ok || got.size() != 289) begin
            failures++;
            $display("FAIL start_held_sweep: done_seen=%0d records=%0d expected 1 289", ok, got.size());
        end
        pos = -1; len = 0;
        for (int k = 1; k <= 6; k++) begin
            step;
            if (fz_rst) begin
                if (pos < 0) pos = k;
                len++;
            end
        end
        checks++;
        if (pos != 2 || len != 2) begin
            failures++;
            $display("FAIL start_held_relaunch: fz_rst first=%0d length=%0d expected 2 2", pos, len);
        end
        start = 1'b0;
        do_reset;
    endtask

    task automatic test_reset_resume;
        got.delete();
        res_ready = 1'b1; start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 3000 && got.size() < 100; k++) step;
        Srst = 1'b1;
        step;
        Srst = 1'b0;
        step;
        step;
        checks++;
        if (got.size() != 100 || res_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort: records=%0d res_valid=%b busy=%b expected 100 0 0", got.size(), res_valid, busy);
        end
        got.delete();
        start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 100 && got.size() < 1; k++) step;
        checks++;
        if (got.size() < 1 || got[0] !== 24'h010100) begin
            failures++;
            $display("FAIL resume_first: records=%0d first=%h expected first=010100", got.size(), (got.size() >= 1) ? got[0] : 24'h0);
        end
        do_reset;
    endtask

    task automatic test_random_backpressure;
        bit ok, pv, pr, v, r;
        logic [23:0] pd, d;
        int viol, eviol, bad;
        viol = 0; eviol = 0; bad = 0; ok = 1'b0;
        pv = 1'b0; pr = 1'b0; pd = '0;
        got.delete();
        res_ready = 1'b0; start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 20000; k++) begin
            step;
            v = res_valid;
            d = res_data;
            if (pv && !pr && (!v || d !== pd)) viol++;
            if (v && {Entrada_01, Entrada_02} !== d[23:8]) eviol++;
            if (done) begin ok = 1'b1; break; end
            r = 1'($urandom_range(0, 1));
            res_ready = r;
            pv = v; pd = d; pr = r;
        end
        checks++;
        if (!ok || got.size() != 289) begin
            failures++;
            $display("FAIL rand_count: done_seen=%0d records=%0d expected 1 289", ok, got.size());
        end
        for (int p = 0; p < got.size() && p < 289; p++) if (got[p] !== exp_rec(p)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_model: mismatching records=%0d expected 0", bad);
        end
        checks++;
        if (viol != 0) begin
            failures++;
            $display("FAIL rand_hold: stall violations=%0d expected 0", viol);
        end
        checks++;
        if (eviol != 0) begin
            failures++;
            $display("FAIL rand_inputs: input/record disagreements=%0d expected 0", eviol);
        end
        do_reset;
    endtask

    task automatic test_latency;
        logic [15:0] prev_e;
        bit prev_v;
        int chg, last_rise, rises;
        srst3 = 1'b1; start3 = 1'b0; ready3 = 1'b1;
        step;
        srst3 = 1'b0; start3 = 1'b1;
        step;
        start3 = 1'b0;
        prev_e = 16'd0; prev_v = 1'b0; chg = -100; last_rise = -1; rises = 0;
        for (int k = 0; k < 120; k++) begin
            step;
            if ({e1_3, e2_3} !== prev_e) begin
                chg = k;
                prev_e = {e1_3, e2_3};
            end
            if (valid3 && !prev_v) begin
                checks++;
                if (k - chg != 4) begin
                    failures++;
                    $display("FAIL lat_valid: valid %0d cycles after input change expected 4", k - chg);
                end
                checks++;
                if (data3 !== exp_rec(rises)) begin
                    failures++;
                    $display("FAIL lat_data: got %h expected %h", data3, exp_rec(rises));
                end
                if (last_rise >= 0) begin
                    checks++;
                    if (k - last_rise != 5) begin
                        failures++;
                        $display("FAIL lat_period: %0d cycles per point expected 5", k - last_rise);
                    end
                end
                last_rise = k;
                rises++;
            end
            prev_v = valid3;
        end
        checks++;
        if (rises < 20) begin
            failures++;
            $display("FAIL lat_points: points=%0d expected at least 20", rises);
        end
        srst3 = 1'b1;
        step;
    endtask

    initial begin
        Srst = 1'b1; start = 1'b0; res_ready = 1'b0;
        srst3 = 1'b1; start3 = 1'b0; ready3 = 1'b0;
        test_reset;
        test_full_sweep;
        test_backpressure;
        test_start_while_busy;
        test_reset_resume;
        test_random_backpressure;
        test_latency;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
